// File: rtl/risc_v_rf_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Optional feature macro used by this slice: RF_WR_BYPASS_EN (write-first reads).
package risc_v_rf_pkg;

   // Architectural defaults for the integer register file.
   localparam int unsigned NUM_REG_DEF        = 32;
   localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
   localparam int unsigned REG_WIDTH_DEF      = 32;

   // Supported port-count limits.
   localparam int unsigned MAX_RD_PORTS = 4;
   localparam int unsigned MAX_WR_PORTS = 2;

   // Index of the hardwired-zero register.
   localparam int unsigned X0_IDX = 0;

   // Widest slice and widest flattened bus the unpack helper handles.
   localparam int unsigned MAX_SLICE_W = 64;
   localparam int unsigned MAX_FLAT_W  = MAX_RD_PORTS * MAX_SLICE_W;

   // Extract slice idx of a flattened port bus whose slices are width bits wide.
   // The caller zero-extends the bus to MAX_FLAT_W and truncates the result.
   function automatic logic [MAX_SLICE_W-1:0] unpack_slice(
      input logic [MAX_FLAT_W-1:0] flat,
      input int unsigned           idx,
      input int unsigned           width
   );
      return MAX_SLICE_W'(flat >> (idx * width));
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the multi-port register file: write ports, read
// ports with registered data/busy, and the issue (scoreboard set) port.
interface reg_file_mp_if
   import risc_v_rf_pkg::*;
#(
   parameter int unsigned NUM_RD_PORTS   = 2,
   parameter int unsigned NUM_WR_PORTS   = 2,
   parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int unsigned REG_WIDTH      = REG_WIDTH_DEF
);
   logic [NUM_WR_PORTS-1:0]                wr_en;
   logic [NUM_WR_PORTS*REG_ADDR_WIDTH-1:0] wr_addr;
   logic [NUM_WR_PORTS*REG_WIDTH-1:0]      wr_data;
   logic [NUM_RD_PORTS-1:0]                rd_en;
   logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD_PORTS*REG_WIDTH-1:0]      rd_data;
   logic [NUM_RD_PORTS-1:0]                rd_busy;
   logic                                   issue_en;
   logic [REG_ADDR_WIDTH-1:0]              issue_rd;

   // Pipeline side: decode/writeback drive requests and collect read results.
   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr, issue_en, issue_rd,
      input  rd_data, rd_busy
   );

   // Register file side.
   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr, issue_en, issue_rd,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Busy scoreboard: one pending-writeback bit per register, set on issue and
// cleared on writeback, plus the registered busy lookup for every read port.
// With RF_WR_BYPASS_EN, a read hitting a same-cycle write sees the post-write
// busy state (busy only if the same cycle re-issues that register).
module rf_scoreboard
   import risc_v_rf_pkg::*;
#(
   parameter int unsigned NUM_REG        = NUM_REG_DEF,
   parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int unsigned NUM_RD_PORTS   = 2,
   parameter int unsigned NUM_WR_PORTS   = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_WR_PORTS-1:0]   wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] wr_addr [NUM_WR_PORTS],
   input  logic                      issue_en,
   input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
   input  logic [NUM_RD_PORTS-1:0]   rd_en,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr [NUM_RD_PORTS],
   output logic [NUM_RD_PORTS-1:0]   rd_busy
);
   localparam logic [REG_ADDR_WIDTH-1:0] X0_ADDR = REG_ADDR_WIDTH'(X0_IDX);

   logic [NUM_REG-1:0]      busy_q, busy_d;
   logic [NUM_RD_PORTS-1:0] rd_busy_q, rd_busy_d;

   // Next busy vector: writebacks clear, issue sets afterwards so it wins.
   always_comb begin
      // NOTE: every always_comb output gets a full default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      busy_d = busy_q;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
         if (wr_en[k]) busy_d[wr_addr[k]] = 1'b0;
      end
      if (issue_en && issue_rd != X0_ADDR) busy_d[issue_rd] = 1'b1;
      busy_d[X0_IDX] = 1'b0;
   end

   // Per-port busy lookup; disabled ports hold their last result.
   always_comb begin
      rd_busy_d = rd_busy_q;
      for (int j = 0; j < NUM_RD_PORTS; j++) begin
         if (rd_en[j]) begin
            rd_busy_d[j] = busy_q[rd_addr[j]];
`ifdef RF_WR_BYPASS_EN
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
               if (wr_en[k] && wr_addr[k] == rd_addr[j] && wr_addr[k] != X0_ADDR)
                  rd_busy_d[j] = issue_en && (issue_rd == rd_addr[j]);
            end
`endif
         end
      end
   end

   // Busy and lookup registers; reset clears every pending writeback.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      if (!reset_n) begin
         busy_q    <= '0;
         rd_busy_q <= '0;
      end else begin
         busy_q    <= busy_d;
         rd_busy_q <= rd_busy_d;
      end
   end

   assign rd_busy = rd_busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with busy scoreboard; x0 reads as zero.
// Reads have one cycle of latency and hold when not enabled. On a write
// collision the highest-index write port wins.
// Optional macro RF_WR_BYPASS_EN: reads see same-cycle writes (write-first);
// undefined, reads return the pre-write contents (read-first).
module reg_file_mp
   import risc_v_rf_pkg::*;
#(
   parameter int unsigned NUM_REG        = NUM_REG_DEF,
   parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int unsigned REG_WIDTH      = REG_WIDTH_DEF,
   parameter int unsigned NUM_RD_PORTS   = 2,
   parameter int unsigned NUM_WR_PORTS   = 2
) (
   input logic           clk,
   input logic           reset_n,
   reg_file_mp_if.slave  bus
);
   localparam logic [REG_ADDR_WIDTH-1:0] X0_ADDR = REG_ADDR_WIDTH'(X0_IDX);

   logic [MAX_FLAT_W-1:0]     wr_addr_flat, wr_data_flat, rd_addr_flat;
   logic [REG_ADDR_WIDTH-1:0] wr_addr_a [NUM_WR_PORTS];
   logic [REG_WIDTH-1:0]      wr_data_a [NUM_WR_PORTS];
   logic [REG_ADDR_WIDTH-1:0] rd_addr_a [NUM_RD_PORTS];

   logic [REG_WIDTH-1:0]      regs_q    [NUM_REG];
   logic [REG_WIDTH-1:0]      regs_d    [NUM_REG];
   logic [REG_WIDTH-1:0]      rd_data_q [NUM_RD_PORTS];
   logic [REG_WIDTH-1:0]      rd_data_d [NUM_RD_PORTS];

   assign wr_addr_flat = MAX_FLAT_W'(bus.wr_addr);
   assign wr_data_flat = MAX_FLAT_W'(bus.wr_data);
   assign rd_addr_flat = MAX_FLAT_W'(bus.rd_addr);

   for (genvar k = 0; k < NUM_WR_PORTS; k++) begin : g_wr_unpack
      assign wr_addr_a[k] = REG_ADDR_WIDTH'(unpack_slice(wr_addr_flat, k, REG_ADDR_WIDTH));
      assign wr_data_a[k] = REG_WIDTH'(unpack_slice(wr_data_flat, k, REG_WIDTH));
   end

   for (genvar j = 0; j < NUM_RD_PORTS; j++) begin : g_rd_unpack
      assign rd_addr_a[j] = REG_ADDR_WIDTH'(unpack_slice(rd_addr_flat, j, REG_ADDR_WIDTH));
      assign bus.rd_data[j*REG_WIDTH +: REG_WIDTH] = rd_data_q[j];
   end

   // Write arbitration: ports applied in index order so the highest one wins.
   always_comb begin
      regs_d = regs_q;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
         if (bus.wr_en[k] && wr_addr_a[k] != X0_ADDR) regs_d[wr_addr_a[k]] = wr_data_a[k];
      end
   end

   // Read mux with optional write-first bypass; disabled ports hold.
   always_comb begin
      rd_data_d = rd_data_q;
      for (int j = 0; j < NUM_RD_PORTS; j++) begin
         if (bus.rd_en[j]) begin
            rd_data_d[j] = regs_q[rd_addr_a[j]];
`ifdef RF_WR_BYPASS_EN
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
               if (bus.wr_en[k] && wr_addr_a[k] == rd_addr_a[j] && wr_addr_a[k] != X0_ADDR)
                  rd_data_d[j] = wr_data_a[k];
            end
`endif
         end
      end
   end

   // Register array and read data registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the array carries an async reset on purpose: architectural
         // registers must read zero after reset, so it maps to flops, not RAM.
         for (int i = 0; i < NUM_REG; i++) regs_q[i] <= '0;
         for (int j = 0; j < NUM_RD_PORTS; j++) rd_data_q[j] <= '0;
      end else begin
         regs_q    <= regs_d;
         rd_data_q <= rd_data_d;
      end
   end

   rf_scoreboard #(
      .NUM_REG       (NUM_REG),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .NUM_RD_PORTS  (NUM_RD_PORTS),
      .NUM_WR_PORTS  (NUM_WR_PORTS)
   ) u_scoreboard (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (bus.wr_en),
      .wr_addr (wr_addr_a),
      .issue_en(bus.issue_en),
      .issue_rd(bus.issue_rd),
      .rd_en   (bus.rd_en),
      .rd_addr (rd_addr_a),
      .rd_busy (bus.rd_busy)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (2 read / 2 write ports, 32x32).
// Expected values follow RF_WR_BYPASS_EN when it is defined for the build.
module tb_reg_file_mp;

`ifdef RF_WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_mis;

   reg_file_mp_if #(
      .NUM_RD_PORTS(2), .NUM_WR_PORTS(2), .REG_ADDR_WIDTH(5), .REG_WIDTH(32)
   ) rf_bus ();

   reg_file_mp dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (rf_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  wr_en;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [1:0]  rd_en;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        iss;
      logic [4:0]  ird;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rf_bus.wr_en    = v.wr_en;
      rf_bus.wr_addr  = {v.wa1, v.wa0};
      rf_bus.wr_data  = {v.wd1, v.wd0};
      rf_bus.rd_en    = v.rd_en;
      rf_bus.rd_addr  = {v.ra1, v.ra0};
      rf_bus.issue_en = v.iss;
      rf_bus.issue_rd = v.ird;
   endtask

   task automatic idle();
      rf_bus.wr_en    = 2'b00;
      rf_bus.wr_addr  = '0;
      rf_bus.wr_data  = '0;
      rf_bus.rd_en    = 2'b00;
      rf_bus.rd_addr  = '0;
      rf_bus.issue_en = 1'b0;
      rf_bus.issue_rd = '0;
   endtask

   // One clock edge, then settle before sampling outputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [1:0] eb);
      check({tag, " rd_data0"}, rf_bus.rd_data[31:0], e0);
      check({tag, " rd_data1"}, rf_bus.rd_data[63:32], e1);
      check({tag, " rd_busy"}, {30'd0, rf_bus.rd_busy}, {30'd0, eb});
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;

      // wr_en wa0 wd0 wa1 wd1 rd_en ra0 ra1 iss ird e0 e1 eb
      vecs[0]  = '{2'b11, 5'd1, 32'h10, 5'd2, 32'h20, 2'b11, 5'd1, 5'd2, 1'b0, 5'd0,
                   BYP ? 32'h10 : 32'h0, BYP ? 32'h20 : 32'h0, 2'b00};
      vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd2, 1'b0, 5'd0,
                   32'h10, 32'h20, 2'b00};
      vecs[2]  = '{2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 2'b11, 5'd7, 5'd1, 1'b0, 5'd0,
                   BYP ? 32'h22222222 : 32'h0, 32'h10, 2'b00};
      vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd0, 1'b0, 5'd0,
                   32'h22222222, 32'h0, 2'b00};
      vecs[4]  = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0,
                   32'h0, 32'h0, 2'b00};
      vecs[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0,
                   32'h0, 32'h0, 2'b00};
      vecs[6]  = '{2'b01, 5'd3, 32'h1, 5'd0, 32'h0, 2'b11, 5'd2, 5'd1, 1'b0, 5'd0,
                   32'h20, 32'h10, 2'b00};
      vecs[7]  = '{2'b10, 5'd0, 32'h0, 5'd3, 32'hA5A5A5A5, 2'b11, 5'd3, 5'd3, 1'b0, 5'd0,
                   BYP ? 32'hA5A5A5A5 : 32'h1, BYP ? 32'hA5A5A5A5 : 32'h1, 2'b00};
      vecs[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3, 1'b0, 5'd0,
                   32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};
      vecs[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, 1'b1, 5'd9,
                   32'h0, 32'h0, 2'b00};
      vecs[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, 1'b0, 5'd0,
                   32'h0, 32'h0, 2'b11};
      vecs[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd1, 1'b0, 5'd0,
                   32'h0, 32'h10, 2'b01};
      vecs[12] = '{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 2'b01, 5'd9, 5'd1, 1'b0, 5'd0,
                   BYP ? 32'h99 : 32'h0, 32'h10, BYP ? 2'b00 : 2'b01};
      vecs[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, 1'b0, 5'd0,
                   32'h99, 32'h99, 2'b00};
      vecs[14] = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h55, 2'b11, 5'd9, 5'd9, 1'b1, 5'd9,
                   BYP ? 32'h55 : 32'h99, BYP ? 32'h55 : 32'h99, BYP ? 2'b11 : 2'b00};
      vecs[15] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9, 1'b0, 5'd0,
                   32'h55, 32'h55, 2'b11};
      vecs[16] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd9, 5'd9, 1'b1, 5'd10,
                   32'h55, 32'h55, 2'b11};
      vecs[17] = '{2'b11, 5'd10, 32'hA, 5'd10, 32'hB, 2'b01, 5'd10, 5'd9, 1'b0, 5'd0,
                   BYP ? 32'hB : 32'h0, 32'h55, BYP ? 2'b10 : 2'b11};
      vecs[18] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd10, 1'b0, 5'd0,
                   32'hB, 32'hB, 2'b00};
      vecs[19] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0,
                   32'h0, 32'h0, 2'b00};
      vecs[20] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 1'b0, 5'd0,
                   32'h0, 32'h0, 2'b00};

      // Power-on reset.
      reset_n = 1'b0;
      idle();
      step();
      step();
      check_out("por", 32'h0, 32'h0, 2'b00);
      reset_n = 1'b1;

      // Table-driven vectors: one cycle each, outputs checked after the edge.
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         step();
         check_out($sformatf("v%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].eb);
      end

      // Hold: rd_en low keeps the old result while x4 is rewritten.
      idle();
      rf_bus.wr_en   = 2'b01;
      rf_bus.wr_addr = {5'd0, 5'd4};
      rf_bus.wr_data = {32'h0, 32'h5};
      step();
      idle();
      rf_bus.rd_en   = 2'b11;
      rf_bus.rd_addr = {5'd4, 5'd4};
      step();
      check_out("hold rd", 32'h5, 32'h5, 2'b00);
      for (int c = 0; c < 3; c++) begin
         rf_bus.rd_en   = 2'b00;
         rf_bus.wr_en   = 2'b01;
         rf_bus.wr_addr = {5'd0, 5'd4};
         rf_bus.wr_data = {32'h0, 32'h6};
         step();
         check_out($sformatf("hold c%0d", c), 32'h5, 32'h5, 2'b00);
      end
      idle();
      rf_bus.rd_en   = 2'b11;
      rf_bus.rd_addr = {5'd4, 5'd4};
      step();
      check_out("hold release", 32'h6, 32'h6, 2'b00);

      // Mid-operation async reset discards the in-flight write and issue.
      idle();
      rf_bus.wr_en    = 2'b01;
      rf_bus.wr_addr  = {5'd0, 5'd5};
      rf_bus.wr_data  = {32'h0, 32'hDEADBEEF};
      rf_bus.issue_en = 1'b1;
      rf_bus.issue_rd = 5'd6;
      #2;
      reset_n = 1'b0;
      #1;
      check_out("async rst", 32'h0, 32'h0, 2'b00);
      step();
      idle();
      rf_bus.rd_en   = 2'b11;
      rf_bus.rd_addr = {5'd6, 5'd5};
      #2;
      reset_n = 1'b1;
      step();
      check_out("post rst x5/x6", 32'h0, 32'h0, 2'b00);
      rf_bus.rd_addr = {5'd10, 5'd9};
      step();
      check_out("post rst x9/x10", 32'h0, 32'h0, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the core's integer register file.
- Provides NUM_RD_PORTS synchronous read ports and NUM_WR_PORTS write ports.
- Includes a per-register busy scoreboard, so ID can detect pending writebacks.
- Sits between decode (read/issue) and writeback (write); x0 is hardwired to zero.

Parameters:
- NUM_REG, 32, number of architectural registers (power of two)
- REG_ADDR_WIDTH, 5, register address width, equals log2(NUM_REG)
- REG_WIDTH, 32, data width per register
- NUM_RD_PORTS, 2, read port count (1..4)
- NUM_WR_PORTS, 2, write port count (1..2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  NUM_WR_PORTS  per-port write enable
- wr_addr  in  NUM_WR_PORTS*REG_ADDR_WIDTH  flattened write addresses; port k at [k*W +: W]
- wr_data  in  NUM_WR_PORTS*REG_WIDTH  flattened write data
- rd_en  in  NUM_RD_PORTS  per-port read enable
- rd_addr  in  NUM_RD_PORTS*REG_ADDR_WIDTH  flattened read addresses
- rd_data  out  NUM_RD_PORTS*REG_WIDTH  registered read data
- rd_busy  out  NUM_RD_PORTS  registered busy flag of the addressed register
- issue_en  in  1  mark issue_rd as pending writeback
- issue_rd  in  REG_ADDR_WIDTH  destination of the issued instruction

Behaviour:
- Reset (async, reset_n=0):
  - all regs, rd_data and busy bits go to 0 immediately; rd_busy goes to 0.
  - Reset mid-operation discards all in-flight writes and issues.
  - The first valid edge is the first rising clk with reset_n=1.
- Writes:
  - On the rising edge, each port k with wr_en[k]=1 and addr!=0 updates regs[addr].
  - Writes to x0 are ignored; x0 always reads 0.
- Write collision:
  - Two ports writing the same address in one cycle: the highest-index port wins.
  - Both ports still clear busy.
- Reads:
  - Latency 1. At the rising edge with rd_en[j]=1, rd_data[j] takes regs[rd_addr[j]] and rd_busy[j] takes busy[rd_addr[j]].
  - With rd_en[j]=0, rd_data[j] and rd_busy[j] hold their previous values.
- Same-cycle read/write conflict: handled per RF_WR_BYPASS_EN (see Optional Feature).
- Scoreboard, one busy bit per register:
  - busy[0] is constantly 0.
  - issue_en with issue_rd!=0 sets busy[issue_rd].
  - Any enabled write port to address a clears busy[a].
  - Set and clear of the same register in the same cycle: set wins, because the newer producer is still outstanding.
  - issue_rd=0 is ignored.
- rd_busy reflects busy before the current edge's update.
  - Exception: with RF_WR_BYPASS_EN, a read whose address matches a same-cycle write reports busy=0, unless the same cycle also issues that register.
- No stall or handshake; every port is accepted every cycle.

Optional Feature:
- Macro: RF_WR_BYPASS_EN
- Defined (write-first):
  - A read that matches an enabled same-cycle write to a nonzero address returns that write's data in rd_data.
  - If several writes match, the highest-index write port's data is returned.
  - The rd_busy exception above applies.
- Undefined (read-first):
  - Reads return the pre-write register contents.
  - rd_busy returns the pre-update busy bit.
  - The pipeline must forward externally.

Decomposition:
- Package risc_v_rf_pkg holds:
  - NUM_REG, REG_ADDR_WIDTH and REG_WIDTH defaults
  - max port counts
  - the x0 index constant
  - an unpack helper function for flattened port slices
- Sub-module rf_scoreboard holds the busy vector, issue/clear priority, and busy lookup for each read port.
- The register array, write arbitration and bypass muxing stay in reg_file_mp.

Test Plan:
- Reset check: assert reset_n=0 mid-write with wr_en[0]=1, addr 5, data 0xDEADBEEF. Expect regs, rd_data and rd_busy at 0. After release, a read of x5 returns 0x00000000.
- x0 protection: write x0=0xFFFFFFFF on both ports, then read x0 on all ports. Expect 0x00000000 and rd_busy=0.
- Write collision: port0 writes x7=0x11111111 and port1 writes x7=0x22222222 in one cycle. A read of x7 on the next cycle returns 0x22222222.
- Bypass:
  - Write x3=0xA5A5A5A5 and read x3 in the same cycle, with x3 previously 0x1.
  - With RF_WR_BYPASS_EN, rd_data is 0xA5A5A5A5.
  - Without RF_WR_BYPASS_EN, rd_data is 0x00000001; it reads 0xA5A5A5A5 one cycle later.
- Scoreboard:
  - Issue x9 at cycle 0; a read of x9 at cycle 1 gives rd_busy=1.
  - Write x9 at cycle 3; a read at cycle 4 gives rd_busy=0.
  - Issue x9 and write x9 in the same cycle; a read next cycle gives rd_busy=1.
- Hold: write x4=0x5, read x4 with rd_en=1, then write x4=0x6 with rd_en=0 for 3 cycles. rd_data stays 0x5 until rd_en=1.
